// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, controller FSM states and byte-lane mask helper
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
    logic [8:0] m;
    m = (9'd1 << (4'd1 << size)) - 9'd1;
    return m[7:0] << off;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts the sized field at offset from word and sign/zero-extends it into rdata
module mem_load_align #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]           word,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [1:0]                size,
  input  logic                      is_unsigned,
  output logic [XLEN-1:0]           rdata
);
  logic [XLEN-1:0] sh, m;
  logic [6:0] nb;
  always_comb begin
    sh = word >> {offset, 3'b000};
    nb = 7'd8 << size;
    m = ~({XLEN{1'b1}} << nb);
    rdata = (sh & m) | ((!is_unsigned && |(sh & (m ^ (m >> 1)))) ? ~m : '0);
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-enabled data memory with req (valid/ready/we/addr/size/unsigned/wdata) and resp (valid/ready/rdata/err) handshakes
module data_mem_ctrl import mem_pkg::*; #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] word_q, wsh, aligned;
  logic [OW-1:0] off, off_q;
  logic [AW-1:0] idx;
  logic [3:0] am;
  logic [7:0] lm;
  logic [1:0] size_q;
  logic err, accept, uns_q, we_q, err_q;
  assign off = req_addr[OW-1:0];
  assign idx = req_addr[OW +: AW];
  assign am = (4'd1 << req_size) - 4'd1;
  assign lm = lane_mask(3'(off), req_size);
  assign wsh = req_wdata << {off, 3'b000};
  assign err = |(req_addr[2:0] & am[2:0]) || |(req_addr >> (OW + AW)) || (XLEN == 32 && req_size == SZ_D);
  assign accept = state == IDLE && req_valid;
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_we && !err)
        for (int i = 0; i < NB; i++)
          if (lm[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      word_q <= mem[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      off_q <= '0;
      size_q <= SZ_B;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        off_q <= off;
        size_q <= req_size;
        uns_q <= req_unsigned;
        we_q <= req_we;
        err_q <= err;
      end
    end
  end
  always_comb begin
    state_d = state == IDLE ? (req_valid ? WAIT : IDLE) :
              state == WAIT ? (cnt == '0 ? RESP : WAIT) :
              (resp_ready ? IDLE : RESP);
    cnt_d = accept ? CW'(READ_LATENCY - 1) : (state == WAIT && cnt != '0) ? cnt - CW'(1) : cnt;
  end
  mem_load_align #(.XLEN(XLEN)) u_align (
    .word(word_q),
    .offset(off_q),
    .size(size_q),
    .is_unsigned(uns_q),
    .rdata(aligned)
  );
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? aligned : '0;
  assign resp_err = resp_valid && err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of three builds (64-bit lat 1, 64-bit lat 4, 32-bit lat 1)
module tb_data_mem_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic rv[3], we[3], un[3], rsr[3], rr[3], vv[3], er[3];
  logic [1:0] sz[3];
  logic [63:0] ad[3], wd[3];
  logic [63:0] rd0, rd1;
  logic [31:0] rd2;
  int n_vec = 0, n_bad = 0;
  data_mem_ctrl #(.XLEN(64), .DEPTH(1024), .READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(we[0]),
    .req_addr(ad[0]), .req_size(sz[0]), .req_unsigned(un[0]), .req_wdata(wd[0]),
    .resp_valid(vv[0]), .resp_ready(rsr[0]), .resp_rdata(rd0), .resp_err(er[0]));
  data_mem_ctrl #(.XLEN(64), .DEPTH(1024), .READ_LATENCY(4)) u1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(we[1]),
    .req_addr(ad[1]), .req_size(sz[1]), .req_unsigned(un[1]), .req_wdata(wd[1]),
    .resp_valid(vv[1]), .resp_ready(rsr[1]), .resp_rdata(rd1), .resp_err(er[1]));
  data_mem_ctrl #(.XLEN(32), .DEPTH(16), .READ_LATENCY(1)) u2 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rr[2]), .req_we(we[2]),
    .req_addr(ad[2][31:0]), .req_size(sz[2]), .req_unsigned(un[2]), .req_wdata(wd[2][31:0]),
    .resp_valid(vv[2]), .resp_ready(rsr[2]), .resp_rdata(rd2), .resp_err(er[2]));
  function automatic logic [63:0] rdsel(input int k);
    return k == 0 ? rd0 : k == 1 ? rd1 : {32'h0, rd2};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input int k, input logic w, input logic [63:0] a, input logic [1:0] s,
                     input logic u, input logic [63:0] d, input int el,
                     output logic [63:0] q, output logic e);
    int n;
    n = 0;
    rsr[k] = 1'b1;
    while (!rr[k] && n < 20) begin @(posedge clk); #1; n++; end
    rv[k] = 1'b1; we[k] = w; ad[k] = a; sz[k] = s; un[k] = u; wd[k] = d;
    @(posedge clk); #1;
    rv[k] = 1'b0;
    n = 0;
    while (!vv[k] && n < 20) begin @(posedge clk); #1; n++; end
    check($sformatf("latency_u%0d", k), 64'(n), 64'(el));
    q = rdsel(k);
    e = er[k];
    @(posedge clk); #1;
  endtask
  logic [63:0] q;
  logic e, seen;
  int n;
  initial begin
    for (int i = 0; i < 3; i++) begin
      rv[i] = 0; we[i] = 0; un[i] = 0; rsr[i] = 0; sz[i] = 0; ad[i] = 0; wd[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_req_ready", 64'(rr[0]), 64'd1);
    check("rst_resp_valid", 64'(vv[0]), 64'd0);
    check("rst_rdata", rd0, 64'd0);
    check("rst_err", 64'(er[0]), 64'd0);
    txn(0, 1, 64'h40, 2'd3, 0, 64'h1122334455667788, 1, q, e);
    check("st_d_rdata", q, 64'd0);
    check("st_d_err", 64'(e), 64'd0);
    txn(0, 0, 64'h40, 2'd3, 0, 64'h0, 1, q, e);
    check("ld_d", q, 64'h1122334455667788);
    check("ld_d_err", 64'(e), 64'd0);
    txn(0, 1, 64'h43, 2'd0, 0, 64'h123456789ABCDE80, 1, q, e);
    txn(0, 0, 64'h43, 2'd0, 0, 64'h0, 1, q, e);
    check("ld_b_signed", q, 64'hFFFFFFFFFFFFFF80);
    txn(0, 0, 64'h43, 2'd0, 1, 64'h0, 1, q, e);
    check("ld_bu", q, 64'h80);
    txn(0, 0, 64'h40, 2'd3, 0, 64'h0, 1, q, e);
    check("ld_d_lane3", q, 64'h1122334480667788);
    txn(0, 0, 64'h42, 2'd1, 0, 64'h0, 1, q, e);
    check("ld_h_signed", q, 64'hFFFFFFFFFFFF8066);
    txn(0, 0, 64'h46, 2'd1, 0, 64'h0, 1, q, e);
    check("ld_h_pos", q, 64'h1122);
    txn(0, 0, 64'h40, 2'd2, 0, 64'h0, 1, q, e);
    check("ld_w_signed", q, 64'hFFFFFFFF80667788);
    txn(0, 0, 64'h40, 2'd2, 1, 64'h0, 1, q, e);
    check("ld_wu", q, 64'h80667788);
    txn(0, 1, 64'h41, 2'd1, 0, 64'hBEEF, 1, q, e);
    check("st_h_misal_err", 64'(e), 64'd1);
    txn(0, 0, 64'h40, 2'd3, 0, 64'h0, 1, q, e);
    check("mem_unchanged", q, 64'h1122334480667788);
    txn(0, 0, 64'h2000, 2'd2, 0, 64'h0, 1, q, e);
    check("oor_err", 64'(e), 64'd1);
    check("oor_rdata", q, 64'd0);
    txn(1, 1, 64'h8, 2'd3, 0, 64'hCAFEF00D12345678, 4, q, e);
    rsr[1] = 1'b0; rv[1] = 1'b1; we[1] = 1'b0; ad[1] = 64'h8; sz[1] = 2'd3; un[1] = 1'b0;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    check("bp_ready_wait", 64'(rr[1]), 64'd0);
    n = 0;
    while (!vv[1] && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_latency", 64'(n), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 64'(vv[1]), 64'd1);
      check("bp_hold_rdata", rd1, 64'hCAFEF00D12345678);
      check("bp_hold_ready", 64'(rr[1]), 64'd0);
      @(posedge clk); #1;
    end
    rsr[1] = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", 64'(vv[1]), 64'd0);
    check("bp_done_ready", 64'(rr[1]), 64'd1);
    rv[1] = 1'b1;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_ready", 64'(rr[1]), 64'd1);
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= vv[1]; end
    check("rst_mid_no_valid", 64'(seen), 64'd0);
    txn(1, 0, 64'h8, 2'd3, 0, 64'h0, 4, q, e);
    check("rst_mid_store_kept", q, 64'hCAFEF00D12345678);
    txn(2, 0, 64'h0, 2'd3, 0, 64'h0, 1, q, e);
    check("x32_ld_d_err", 64'(e), 64'd1);
    txn(2, 1, 64'h8, 2'd2, 0, 64'hDEADBEEF, 1, q, e);
    txn(2, 0, 64'hA, 2'd1, 1, 64'h0, 1, q, e);
    check("x32_ld_hu", q, 64'hDEAD);
    txn(2, 0, 64'hA, 2'd1, 0, 64'h0, 1, q, e);
    check("x32_ld_h_signed", q, 64'hFFFFDEAD);
    txn(2, 0, 64'h40, 2'd2, 0, 64'h0, 1, q, e);
    check("x32_oor_err", 64'(e), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
